pulse_sync_arb: RTL
===================

PULSE_SYNC_ARB -- requirements
Module: pulse_sync_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of fast-domain event requesters (2..8).
REQ-002 Parameter ID_W, default 2, width of event ID; SHALL satisfy 2^ID_W >= N_REQ.
REQ-003 Parameter TO_CYC, default 255, timeout in clk_fast cycles for acknowledge (1..255, 8-bit counter).
REQ-004 clk_fast  input  1  fast-domain clock, all logic rising-edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 req  input  N_REQ  single-cycle event pulses, one bit per requester.
REQ-007 sync_req  output  1  level to the slow domain; high = event in flight.
REQ-008 sync_id  output  ID_W  index of the in-flight requester, valid while sync_req high.
REQ-009 sync_ack  input  1  slow-domain echo of sync_req, already double-flopped into clk_fast.
REQ-010 busy  output  1  high whenever FSM is not IDLE.
REQ-011 ovf  output  N_REQ  sticky per-requester overflow flags.
REQ-012 ovf_clr  input  1  single-cycle clear of all ovf bits.
REQ-013 timeout  output  1  single-cycle pulse on acknowledge timeout.

Function
REQ-014 Each requester SHALL have one pending bit; req[i]=1 sets pending[i] on the next edge.
REQ-015 req[i]=1 while pending[i] is already 1 and not being granted that cycle SHALL set ovf[i]; events merge, pending[i] stays 1.
REQ-016 req[i]=1 in the same cycle pending[i] is granted SHALL leave pending[i]=1 (new event queued) and SHALL NOT set ovf[i].
REQ-017 ovf_clr SHALL clear ovf the next cycle; a simultaneous overflow event SHALL win (bit ends 1).
REQ-018 FSM states: IDLE, ASSERT, RELEASE.
REQ-019 IDLE: if any pending bit set, grant the round-robin winner; next cycle sync_req=1, sync_id=winner, pending[winner]=0, state ASSERT.
REQ-020 Round-robin: search starts at pointer ptr (reset 0), ascending with wrap; after grant of i, ptr=(i+1) mod N_REQ.
REQ-021 ASSERT: hold sync_req=1 and sync_id stable; on sync_ack=1 deassert sync_req next cycle, state RELEASE.
REQ-022 ASSERT: 8-bit counter clears on entry, increments each cycle; when it reaches TO_CYC with sync_ack=0, pulse timeout for one cycle, deassert sync_req, state RELEASE.
REQ-023 RELEASE: sync_req=0; remain until sync_ack=0, then IDLE next cycle.
REQ-024 No new grant SHALL occur until sync_ack has been observed 0 in RELEASE (return-to-zero handshake complete).
REQ-025 A requester's event SHALL be granted within N_REQ handshakes of becoming pending (no starvation).
REQ-026 sync_req and sync_id SHALL be driven directly from flops (no glitches into the slow domain).
REQ-027 sync_id SHALL change only on the IDLE->ASSERT transition.

Reset
REQ-028 rstn low SHALL asynchronously force: state IDLE, sync_req=0, sync_id=0, pending=0, ovf=0, ptr=0, counter=0, timeout=0, busy=0.
REQ-029 Reset mid-handshake SHALL abandon the in-flight event and all pending events; no replay after release.
REQ-030 First grant SHALL be possible on the first edge after rstn deasserts.

Verification
REQ-031 Single event: req=4'b0100 one cycle, ack echoes 3 cycles after sync_req -> sync_req high with sync_id=2, drops 1 cycle after ack=1, busy low 1 cycle after ack=0.
REQ-032 Contention: req=4'b1111 same cycle, ack echo model -> grants in order 0,1,2,3; ptr ends 0; no ovf.
REQ-033 Overflow: req[1] pulsed twice while requester 0 in flight -> ovf=4'b0010, only one grant for id 1; ovf_clr -> ovf=0.
REQ-034 Timeout: TO_CYC=16, sync_ack tied 0 -> timeout pulse 16 cycles after ASSERT entry, sync_req drops, next pending event granted after RELEASE.
REQ-035 Simultaneous grant/request: req[0] pulsed in the IDLE grant cycle of id 0 -> second grant of id 0 follows, ovf[0]=0.
REQ-036 Reset mid-ASSERT with pending=4'b1010 -> all outputs zero immediately; no grant after rstn release without new req.

Source files
------------

// File: rtl/pulse_sync_arb.sv
// pulse_sync_arb: collects single-cycle event pulses from N_REQ fast-domain
// requesters and forwards them one at a time to a slow domain over a
// four-phase level handshake.
// Arbitration is round-robin. Repeated events from a requester that is still
// waiting are merged into one and flagged in a sticky overflow bit. A stalled
// acknowledge is abandoned after TO_CYC cycles.
module pulse_sync_arb #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int TO_CYC = 255
) (
  input  logic             clk_fast,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  output logic             sync_req,
  output logic [ID_W-1:0]  sync_id,
  input  logic             sync_ack,
  output logic             busy,
  output logic [N_REQ-1:0] ovf,
  input  logic             ovf_clr,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    RELEASE
  } state_t;

  // LAST_ID is the highest requester index, used to wrap the round-robin search.
  // TO_LAST is the ASSERT-cycle count at which the next edge times out.
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [7:0]      TO_LAST = 8'(TO_CYC - 1);

  state_t            state_q;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [N_REQ-1:0]  ovf_q, ovf_d;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   sync_id_q;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;
  logic              any_pending;
  logic              grant_en;
  logic              sync_req_q;
  logic              timeout_q;
  logic [7:0]        cnt_q;

  // Round-robin search: scan upward from ptr with wrap; the first pending bit wins.
  always_comb begin
    winner      = ptr_q;
    any_pending = 1'b0;
    cand        = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_pending && pending_q[cand]) begin
        winner      = cand;
        any_pending = 1'b1;
      end
      cand = (cand == LAST_ID) ? '0 : cand + ID_W'(1);
    end
  end

  // A grant is only issued from IDLE, which implies the previous
  // return-to-zero handshake has completed.
  assign grant_en = (state_q == IDLE) && any_pending;
  assign grant    = grant_en ? (N_REQ'(1) << winner) : '0;

  // Next-state logic for the pending bits and the overflow bits.
  // A new pulse always re-arms its pending bit, so a pulse that arrives in
  // the grant cycle queues a fresh event. A pulse counts as an overflow only
  // when it lands on a pending bit that is not being granted. Overflow takes
  // precedence over a clear that arrives in the same cycle.
  always_comb begin
    pending_d = (pending_q & ~grant) | req;
    ovf_d     = (ovf_q & ~{N_REQ{ovf_clr}}) | (req & pending_q & ~grant);
  end

  // Register the pending and overflow bits.
  always_ff @(posedge clk_fast or negedge rstn) begin
    if (!rstn) begin
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  // Handshake FSM.
  // sync_req, sync_id and timeout are all flops, so the slow domain never
  // sees glitches. sync_id is loaded only when the FSM leaves IDLE.
  always_ff @(posedge clk_fast or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      sync_req_q <= 1'b0;
      sync_id_q  <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            state_q    <= ASSERT;
            sync_req_q <= 1'b1;
            sync_id_q  <= winner;
            cnt_q      <= '0;
            ptr_q      <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
          end
        end
        ASSERT: begin
          cnt_q <= cnt_q + 8'd1;
          if (sync_ack) begin
            sync_req_q <= 1'b0;
            state_q    <= RELEASE;
          end else if (cnt_q == TO_LAST) begin
            timeout_q  <= 1'b1;
            sync_req_q <= 1'b0;
            state_q    <= RELEASE;
          end
        end
        RELEASE: begin
          if (!sync_ack) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sync_req = sync_req_q;
  assign sync_id  = sync_id_q;
  assign timeout  = timeout_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q != IDLE);

endmodule
